msg_pack: RTL

- Reverse of the memory-copy block. Accepts a byte stream over a valid/ready interface and writes it into a 256x8 length-prefixed message memory.
- Memory layout: byte 0 holds the message length N; bytes 1..N hold the payload.
- Used to load plaintext or ciphertext buffers from a host/stream source before the ARC4 engine runs.
- Uses the codebase's en/rdy request protocol toward the top-level controller.

---
 rtl/arc4_pkg.sv | 22 ++
 rtl/msg_wr_stage.sv | 47 ++++
 rtl/msg_pack.sv | 139 +++++++++++++
 3 files changed

// File: rtl/arc4_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arc4_pkg
// Description : Shared types and constants for the ARC4 message-memory blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package arc4_pkg;

  // Message-packer control states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRLEN = 2'd2
  } msg_state_e;

  // Byte 0 of the message memory holds the payload length
  localparam logic [7:0] MSG_LEN_ADDR = 8'd0;
  // Largest payload that fits behind the length byte in a 256-entry memory
  localparam logic [7:0] MSG_MAX_LEN  = 8'd255;

endpackage
`default_nettype wire

// File: rtl/msg_wr_stage.sv
`default_nettype none
// ============================================================================
// Module      : msg_wr_stage
// Description : Registered write port for a synchronous-write RAM. A load
//               presents addr/data/valid on the following cycle; without a
//               load the valid drops and addr/data hold their last value.
// Revision    : 1.0 - initial release
// ============================================================================
module msg_wr_stage #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] data_i,
  output logic          valid_o,
  output logic [AW-1:0] addr_o,
  output logic [DW-1:0] data_o
);

  logic          valid_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] data_q;

  // Capture one write per load; reset drops any write in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= load_i;
      if (load_i) begin
        addr_q <= addr_i;
        data_q <= data_i;
      end
    end
  end

  assign valid_o = valid_q;
  assign addr_o  = addr_q;
  assign data_o  = data_q;

endmodule
`default_nettype wire

// File: rtl/msg_pack.sv
`default_nettype none
// ============================================================================
// Module      : msg_pack
// Description : Packs a valid/ready byte stream into a length-prefixed message
//               memory: payload at addresses 1..N, then N written to address 0.
//               Started through the en/rdy request handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module msg_pack
  import arc4_pkg::*;
#(
  parameter int unsigned MAX_LEN = 32'(MSG_MAX_LEN)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       rdy,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wrdata,
  output logic       mem_wren,
  output logic [7:0] msg_len,
  output logic       overflow
);

  // 9-bit so a full 255-byte payload count never aliases to zero
  localparam logic [8:0] C_MAX_LEN = 9'(MAX_LEN);

  msg_state_e state_q;
  logic [8:0] count_q;
  logic       rdy_q;
  logic       in_ready_q;
  logic       overflow_q;
  logic [7:0] msg_len_q;

  logic       accept;
  logic [8:0] count_inc;
  logic       wr_load_d;
  logic [7:0] wr_addr_d;
  logic [7:0] wr_data_d;

  // in_ready_q is only ever high while in RECV
  assign accept    = in_valid & in_ready_q;
  assign count_inc = count_q + 9'd1;

  // Select what the write stage captures this cycle: a payload byte or the length
  always_comb begin
    wr_load_d = 1'b0;
    wr_addr_d = MSG_LEN_ADDR;
    wr_data_d = count_q[7:0];
    case (state_q)
      RECV: begin
        if (accept) begin
          wr_load_d = 1'b1;
          wr_addr_d = count_inc[7:0];
          wr_data_d = in_data;
        end
      end
      WRLEN: begin
        wr_load_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Control FSM; rdy/in_ready are registered alongside the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      count_q    <= '0;
      rdy_q      <= 1'b1;
      in_ready_q <= 1'b0;
      overflow_q <= 1'b0;
      msg_len_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // rdy is held low for the length-write cycle, which masks en there
          if (!rdy_q) begin
            rdy_q <= 1'b1;
          end else if (en) begin
            count_q    <= '0;
            overflow_q <= 1'b0;
            rdy_q      <= 1'b0;
            in_ready_q <= 1'b1;
            state_q    <= RECV;
          end
        end
        RECV: begin
          if (accept) begin
            count_q <= count_inc;
            if (in_last) begin
              in_ready_q <= 1'b0;
              state_q    <= WRLEN;
            end else if (count_inc == C_MAX_LEN) begin
              overflow_q <= 1'b1;
              in_ready_q <= 1'b0;
              state_q    <= WRLEN;
            end
          end
        end
        WRLEN: begin
          msg_len_q <= count_q[7:0];
          state_q   <= IDLE;
        end
        default: begin
          state_q    <= IDLE;
          rdy_q      <= 1'b0;
          in_ready_q <= 1'b0;
        end
      endcase
    end
  end

  msg_wr_stage #(
    .AW(8),
    .DW(8)
  ) u_wr_stage (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (wr_load_d),
    .addr_i (wr_addr_d),
    .data_i (wr_data_d),
    .valid_o(mem_wren),
    .addr_o (mem_addr),
    .data_o (mem_wrdata)
  );

  assign rdy      = rdy_q;
  assign in_ready = in_ready_q;
  assign msg_len  = msg_len_q;
  assign overflow = overflow_q;

endmodule
`default_nettype wire
